// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: IDLE -> DECODE -> EXEC -> (MEM) -> WB,
// with a cache-handshake watchdog and a sticky TRAP state that only reset leaves.
module multicycle_ctrl #(
    parameter int Data_Width  = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [Data_Width-1:0] instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic                  eq,
    input  logic                  mem_ready,
    output logic                  regFileWen,
    output logic                  ALUSrc,
    output logic [3:0]            ALU_ctrl,
    output logic [2:0]            ImmSrc,
    output logic                  MemWrite,
    output logic [1:0]            dataType,
    output logic                  SrcSel,
    output logic                  JumpSel,
    output logic                  pc_en,
    output logic                  pc_branch,
    output logic                  trap,
    output logic [1:0]            trap_cause
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] TRAP   = 3'd5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    localparam int         CW       = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    logic [2:0]            state;
    logic [Data_Width-1:0] ir;
    logic [CW-1:0]         cnt;
    logic [1:0]            cause;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7b5;
    logic       is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_lui;
    logic       legal;
    logic [3:0] alu_op;
    logic       unused_ir_bits;

    assign opcode   = ir[6:0];
    assign f3       = ir[14:12];
    assign f7b5     = ir[30];
    // Register/immediate fields are consumed by the datapath, not the sequencer.
    assign unused_ir_bits = ^{ir[Data_Width-1:31], ir[29:15], ir[11:7]};

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_br    = (opcode == OP_BR);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_lui   = (opcode == OP_LUI);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R, OP_I:        legal = (f3 != 3'b011);
            OP_LOAD, OP_STORE: legal = (f3 <= 3'b010);
            OP_BR:             legal = (f3[2:1] == 2'b00);
            OP_JAL, OP_LUI:    legal = 1'b1;
            OP_JALR:           legal = (f3 == 3'b000);
            default:           legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        case (f3)
            3'b000:  alu_op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the instruction
    // register is reset explicitly because the decode below reads it in every state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ir    <= '0;
            cnt   <= '0;
            cause <= 2'b00;
        end else begin
            case (state)
                IDLE: if (instr_valid) begin
                    ir    <= instr;
                    state <= DECODE;
                end
                DECODE: if (!legal) begin
                    state <= TRAP;
                    cause <= 2'b01;
                end else begin
                    state <= EXEC;
                end
                EXEC: begin
                    cnt <= '0;
                    if (is_load || is_store) state <= MEM;
                    else if (is_br)          state <= IDLE;
                    else                     state <= WB;
                end
                MEM: if (mem_ready) begin
                    state <= is_store ? IDLE : WB;
                end else if (cnt == CNT_LAST) begin
                    state <= TRAP;
                    cause <= 2'b10;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                WB:      state <= IDLE;
                TRAP:    state <= TRAP;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst_n is held, whatever state is still registered.
    always_comb begin
        instr_ready = 1'b0;
        regFileWen  = 1'b0;
        ALUSrc      = 1'b0;
        ALU_ctrl    = ALU_ADD;
        ImmSrc      = 3'b000;
        MemWrite    = 1'b0;
        dataType    = 2'b00;
        SrcSel      = 1'b0;
        JumpSel     = 1'b0;
        pc_en       = 1'b0;
        pc_branch   = 1'b0;
        trap        = 1'b0;
        trap_cause  = 2'b00;
        if (rst_n) begin
            case (state)
                IDLE: instr_ready = 1'b1;
                EXEC: begin
                    ALUSrc = !(is_r || is_br);
                    if (is_r || is_i) ALU_ctrl = alu_op;
                    else if (is_br)   ALU_ctrl = ALU_SUB;
                    if (is_store)     ImmSrc = 3'b001;
                    else if (is_br)   ImmSrc = 3'b010;
                    else if (is_lui)  ImmSrc = 3'b011;
                    else if (is_jal)  ImmSrc = 3'b100;
                    pc_en     = is_br;
                    pc_branch = is_br && (f3[0] ? !eq : eq);
                end
                MEM: begin
                    MemWrite = is_store;
                    SrcSel   = is_load;
                    case (f3)
                        3'b000:  dataType = 2'b01;
                        3'b001:  dataType = 2'b10;
                        default: dataType = 2'b00;
                    endcase
                    pc_en = is_store && mem_ready;
                end
                WB: begin
                    regFileWen = 1'b1;
                    pc_en      = 1'b1;
                    SrcSel     = is_load;
                    JumpSel    = is_jal || is_jalr;
                    pc_branch  = is_jal || is_jalr;
                end
                TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause;
                end
                default: ;
            endcase
        end
    end

endmodule
